// File: rtl/wb_arbiter_pkg.sv
// wb_arbiter_pkg: shared writeback definitions.
//   LEN_WORD       - register-file data width
//   LEN_REG_ADDR   - destination encoding width ([5]=float file, [4:0]=index)
//   REG_FLOAT_BIT  - position of the float-file select bit
//   REG_ZERO       - integer x0, whose writes are discarded
//   wb_entry_t     - one pending register-file write (destination + data)
//   gnt_e          - which candidate owns the write port this cycle
package wb_arbiter_pkg;

  localparam int unsigned LEN_WORD      = 32;
  localparam int unsigned LEN_REG_ADDR  = 6;
  localparam int unsigned REG_FLOAT_BIT = 5;
  localparam logic [LEN_REG_ADDR-1:0] REG_ZERO = 6'b000000;

  typedef struct packed {
    logic [LEN_REG_ADDR-1:0] rd;
    logic [LEN_WORD-1:0]     data;
  } wb_entry_t;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_F    = 2'd1,
    GNT_M    = 2'd2
  } gnt_e;

  // x0 is hard-wired zero; f0 (float bit set) is an ordinary register.
  function automatic logic is_reg_zero(input logic [LEN_REG_ADDR-1:0] rd);
    return !rd[REG_FLOAT_BIT] && (rd[REG_FLOAT_BIT-1:0] == REG_ZERO[REG_FLOAT_BIT-1:0]);
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: circular buffer with occupancy count for buffered 1-cycle results.
//   clk, rstn  - clock, asynchronous active-low reset (pointers/count only)
//   push, din  - enqueue din at the tail (ignored when full)
//   pop, dout  - dequeue the head; dout always shows the current head
//   full/empty - occupancy flags
// DEPTH must be a power of two >= 2 so the pointers wrap naturally.
module wb_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 38
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  // Storage carries no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: writeback stage merging 1-cycle exec results (s1_*) and
// multi-cycle unit results (sm_*) onto one registered register-file port.
//   clk, rstn            - clock, asynchronous active-low reset
//   s1_valid/ready/reg/data - 1-cycle results; buffered in wb_fifo when the
//                          port is taken, s1_ready = FIFO not full
//   sm_valid/ready/reg/data - multi-cycle results; sm_ready pulses on grant
//   wb_en/reg/data       - registered register-file write
//   empty                - nothing buffered and no write in the output register
//   stall_cnt            - (WB_STALL_CNT_EN only) cycles s1 was back-pressured
// Optional feature macro: WB_STALL_CNT_EN.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH        = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    s1_valid,
  output logic                    s1_ready,
  input  logic [LEN_REG_ADDR-1:0] s1_reg,
  input  logic [LEN_WORD-1:0]     s1_data,
  input  logic                    sm_valid,
  output logic                    sm_ready,
  input  logic [LEN_REG_ADDR-1:0] sm_reg,
  input  logic [LEN_WORD-1:0]     sm_data,
  output logic                    wb_en,
  output logic [LEN_REG_ADDR-1:0] wb_reg,
  output logic [LEN_WORD-1:0]     wb_data,
  output logic                    empty
`ifdef WB_STALL_CNT_EN
  ,
  output logic [31:0]             stall_cnt
`endif
);

  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  wb_entry_t s1_ent, m_ent, head_ent, f_ent, win_ent;
  logic      fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic      f_valid;
  gnt_e      gnt;

  logic [SW-1:0]           starve_q, starve_d;
  logic                    wb_en_q, wb_en_d;
  logic [LEN_REG_ADDR-1:0] wb_reg_q, wb_reg_d;
  logic [LEN_WORD-1:0]     wb_data_q, wb_data_d;

  assign s1_ent = '{rd: s1_reg, data: s1_data};
  assign m_ent  = '{rd: sm_reg, data: sm_data};

  wb_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(wb_entry_t))
  ) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (s1_ent),
    .dout  (head_ent),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign s1_ready = !fifo_full;

  // F candidate: FIFO head, or the incoming s1 result bypassing an empty FIFO.
  assign f_valid = !fifo_empty || s1_valid;
  assign f_ent   = fifo_empty ? s1_ent : head_ent;

  always_comb begin
    gnt = GNT_NONE;
    if (sm_valid && (!f_valid || starve_q != STARVE_MAX)) gnt = GNT_M;
    else if (f_valid)                                      gnt = GNT_F;
  end

  assign sm_ready = (gnt == GNT_M);
  assign fifo_pop = (gnt == GNT_F) && !fifo_empty;
  // A bypassed s1 result goes straight to the output register, never the FIFO.
  assign fifo_push = s1_valid && s1_ready && !((gnt == GNT_F) && fifo_empty);
  assign win_ent   = (gnt == GNT_M) ? m_ent : f_ent;

  always_comb begin
    starve_d = '0;
    if ((gnt == GNT_M) && f_valid)
      starve_d = (starve_q == STARVE_MAX) ? starve_q : starve_q + 1'b1;
  end

  // An x0 winner is consumed without a write and leaves wb_reg/wb_data untouched.
  always_comb begin
    wb_en_d   = 1'b0;
    wb_reg_d  = wb_reg_q;
    wb_data_d = wb_data_q;
    if ((gnt != GNT_NONE) && !is_reg_zero(win_ent.rd)) begin
      wb_en_d   = 1'b1;
      wb_reg_d  = win_ent.rd;
      wb_data_d = win_ent.data;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      starve_q  <= '0;
      wb_en_q   <= 1'b0;
      wb_reg_q  <= '0;
      wb_data_q <= '0;
    end else begin
      starve_q  <= starve_d;
      wb_en_q   <= wb_en_d;
      wb_reg_q  <= wb_reg_d;
      wb_data_q <= wb_data_d;
    end
  end

  assign wb_en   = wb_en_q;
  assign wb_reg  = wb_reg_q;
  assign wb_data = wb_data_q;
  assign empty   = fifo_empty && !wb_en_q;

`ifdef WB_STALL_CNT_EN
  logic [31:0] stall_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                     stall_q <= '0;
    else if (s1_valid && !s1_ready) stall_q <= stall_q + 1'b1;
  end

  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
module tb_wb_arbiter;
  import wb_arbiter_pkg::*;

  localparam int DEPTH = 2;
  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rstn;
  logic        s1_valid, s1_ready, sm_valid, sm_ready, wb_en, empty;
  logic [5:0]  s1_reg, sm_reg, wb_reg;
  logic [31:0] s1_data, sm_data, wb_data;
`ifdef WB_STALL_CNT_EN
  logic [31:0] stall_cnt;
  int unsigned exp_stall;
`endif

  wb_arbiter #(
    .DEPTH        (DEPTH),
    .STARVE_LIMIT (LIMIT)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .s1_valid (s1_valid),
    .s1_ready (s1_ready),
    .s1_reg   (s1_reg),
    .s1_data  (s1_data),
    .sm_valid (sm_valid),
    .sm_ready (sm_ready),
    .sm_reg   (sm_reg),
    .sm_data  (sm_data),
    .wb_en    (wb_en),
    .wb_reg   (wb_reg),
    .wb_data  (wb_data),
    .empty    (empty)
`ifdef WB_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  wb_entry_t   mq[$];        // results waiting in the writeback buffer
  int          starve;
  logic        exp_wb_en;
  logic [5:0]  exp_wb_reg;
  logic [31:0] exp_wb_data;
  bit          last_s1_acc, last_m_win;

  always @(negedge clk) begin
    if (!rstn) begin
      mq.delete();
      starve = 0;
      exp_wb_en = 1'b0; exp_wb_reg = '0; exp_wb_data = '0;
      last_s1_acc = 0; last_m_win = 0;
      chk("rst_wb_en", wb_en, 0);
      chk("rst_wb_reg", wb_reg, 0);
      chk("rst_wb_data", wb_data, 0);
      chk("rst_s1_ready", s1_ready, 1);
      chk("rst_sm_ready", sm_ready, 0);
      chk("rst_empty", empty, 1);
`ifdef WB_STALL_CNT_EN
      exp_stall = 0;
      chk("rst_stall_cnt", stall_cnt, 0);
`endif
    end else begin
      bit        room, f_avail, m_win, f_win, bypass, acc;
      wb_entry_t fe, w;
      room    = (mq.size() < DEPTH);
      f_avail = (mq.size() > 0) || s1_valid;
      if (mq.size() > 0) fe = mq[0];
      else begin fe.rd = s1_reg; fe.data = s1_data; end
      m_win  = sm_valid && (!f_avail || starve < LIMIT);
      f_win  = f_avail && !m_win;
      bypass = f_win && (mq.size() == 0);
      acc    = s1_valid && room;

      chk("s1_ready", s1_ready, room);
      chk("sm_ready", sm_ready, m_win);
      chk("wb_en", wb_en, exp_wb_en);
      chk("wb_reg", wb_reg, exp_wb_reg);
      chk("wb_data", wb_data, exp_wb_data);
      chk("empty", empty, (mq.size() == 0) && !exp_wb_en);
`ifdef WB_STALL_CNT_EN
      chk("stall_cnt", stall_cnt, exp_stall);
      if (s1_valid && !room) exp_stall++;
`endif

      if (f_win && !bypass) void'(mq.pop_front());
      if (acc && !bypass) begin
        wb_entry_t e;
        e.rd = s1_reg; e.data = s1_data;
        mq.push_back(e);
      end

      if (m_win) begin w.rd = sm_reg; w.data = sm_data; end
      else       w = fe;
      if ((m_win || f_win) && w.rd != 6'd0) begin
        exp_wb_en = 1'b1; exp_wb_reg = w.rd; exp_wb_data = w.data;
      end else begin
        exp_wb_en = 1'b0;
      end

      if (m_win && f_avail) starve = (starve < LIMIT) ? starve + 1 : starve;
      else                  starve = 0;

      last_s1_acc = acc;
      last_m_win  = m_win;
    end
  end

  // ---------------- stimulus ----------------
  wb_entry_t s1_src[$];
  wb_entry_t sm_src[$];

  task automatic drive();
    s1_valid = (s1_src.size() > 0);
    s1_reg   = (s1_src.size() > 0) ? s1_src[0].rd   : 6'd0;
    s1_data  = (s1_src.size() > 0) ? s1_src[0].data : 32'd0;
    sm_valid = (sm_src.size() > 0);
    sm_reg   = (sm_src.size() > 0) ? sm_src[0].rd   : 6'd0;
    sm_data  = (sm_src.size() > 0) ? sm_src[0].data : 32'd0;
  endtask

  // Advance one cycle; sources only move on after their handshake completed.
  task automatic step();
    @(posedge clk); #1;
    if (last_s1_acc && s1_src.size() > 0) void'(s1_src.pop_front());
    if (last_m_win && sm_src.size() > 0) void'(sm_src.pop_front());
    drive();
  endtask

  task automatic add_s1(input logic [5:0] r, input logic [31:0] d);
    wb_entry_t e; e.rd = r; e.data = d; s1_src.push_back(e);
  endtask

  task automatic add_sm(input logic [5:0] r, input logic [31:0] d);
    wb_entry_t e; e.rd = r; e.data = d; sm_src.push_back(e);
  endtask

  task automatic drain();
    int n = 0;
    while ((s1_src.size() > 0 || sm_src.size() > 0) && n < 200) begin
      step(); n++;
    end
    chk("drain_timeout", (n < 200), 1);
    repeat (3) step();
  endtask

  bit exp_smr [6] = '{1, 1, 1, 1, 0, 1};
  bit exp_s1r [6] = '{1, 1, 0, 0, 0, 1};

  initial begin
    rstn = 1'b0;
    drive();
    #2;
    chk("init_wb_en", wb_en, 0);
    chk("init_s1_ready", s1_ready, 1);
    chk("init_empty", empty, 1);
    #10 rstn = 1'b1;

    // Continuous s1 and sm pressure: s1 stalls in 7 of the first 10 cycles.
    for (int i = 0; i < 6; i++)  add_s1(6'd1 + 6'(i), 32'h0000_0B00 + i);
    for (int i = 0; i < 10; i++) add_sm(6'h21 + 6'(i), 32'h0000_0C00 + i);
    repeat (11) step();
`ifdef WB_STALL_CNT_EN
    #1 chk("stall_cnt_7", stall_cnt, 32'd7);
`endif
    drain();

    // Uncontended s1: one-cycle latency.
    add_s1(6'd5, 32'h0000_002A);
    step();
    step(); #1;
    chk("unc_wb_en", wb_en, 1);
    chk("unc_wb_reg", wb_reg, 6'd5);
    chk("unc_wb_data", wb_data, 32'h0000_002A);
    chk("unc_empty", empty, 0);
    step(); #1;
    chk("unc_idle_wb_en", wb_en, 0);
    chk("unc_idle_empty", empty, 1);

    // x0 consumed without a write; f0 written normally.
    add_s1(6'd0, 32'hFFFF_FFFF);
    step();
    step(); #1;
    chk("x0_wb_en", wb_en, 0);
    chk("x0_wb_reg_held", wb_reg, 6'd5);
    chk("x0_wb_data_held", wb_data, 32'h0000_002A);
    chk("x0_empty", empty, 1);
    add_sm(6'h20, 32'h3F80_0000);
    step(); #1;
    chk("f0_sm_ready", sm_ready, 1);
    step(); #1;
    chk("f0_wb_en", wb_en, 1);
    chk("f0_wb_reg", wb_reg, 6'h20);
    chk("f0_wb_data", wb_data, 32'h3F80_0000);
    repeat (2) step();

    // Contention: sm every cycle, three s1 results back-to-back.
    add_s1(6'd1, 32'h0000_00A1);
    add_s1(6'd2, 32'h0000_00A2);
    add_s1(6'd3, 32'h0000_00A3);
    for (int i = 0; i < 8; i++) add_sm(6'h10 + 6'(i), 32'h0000_0100 + i);
    for (int k = 0; k < 6; k++) begin
      step(); #1;
      chk($sformatf("cont_sm_ready_%0d", k), sm_ready, exp_smr[k]);
      chk($sformatf("cont_s1_ready_%0d", k), s1_ready, exp_s1r[k]);
      if (k == 4) chk("cont_last_sm_reg", wb_reg, 6'h13);
      if (k == 5) begin
        chk("cont_head_wb_en", wb_en, 1);
        chk("cont_head_wb_reg", wb_reg, 6'd1);
        chk("cont_head_wb_data", wb_data, 32'h0000_00A1);
      end
    end
    drain();

    // Simultaneous push and pop with one buffered entry.
    add_s1(6'd7, 32'h0000_0077);
    add_s1(6'd8, 32'h0000_0088);
    add_sm(6'd9, 32'h0000_0099);
    step(); #1;
    chk("pp_sm_ready", sm_ready, 1);
    step(); #1;
    chk("pp_sm_written", wb_reg, 6'd9);
    chk("pp_s1_ready", s1_ready, 1);
    chk("pp_sm_ready_idle", sm_ready, 0);
    step(); #1;
    chk("pp_head_reg", wb_reg, 6'd7);
    chk("pp_head_data", wb_data, 32'h0000_0077);
    chk("pp_not_empty", empty, 0);
    step(); #1;
    chk("pp_new_reg", wb_reg, 6'd8);
    chk("pp_new_data", wb_data, 32'h0000_0088);
    step(); #1;
    chk("pp_done_wb_en", wb_en, 0);
    chk("pp_done_empty", empty, 1);

    // Asynchronous reset with two entries buffered.
    add_s1(6'h0A, 32'h0000_00AA);
    add_s1(6'h0B, 32'h0000_00BB);
    for (int i = 0; i < 3; i++) add_sm(6'h18 + 6'(i), 32'h0000_0180 + i);
    repeat (3) step();
    #2 rstn = 1'b0;
    s1_src.delete();
    sm_src.delete();
    drive();
    #1;
    chk("arst_wb_en", wb_en, 0);
    chk("arst_wb_reg", wb_reg, 0);
    chk("arst_wb_data", wb_data, 0);
    chk("arst_s1_ready", s1_ready, 1);
    chk("arst_empty", empty, 1);
    @(posedge clk); #3 rstn = 1'b1;
    repeat (6) begin
      step(); #1;
      chk("post_rst_wb_en", wb_en, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
